pe_write_port: RTL

- Per-PE front end for mesh writes. Buffers local write requests (addr = destination PE, data) and injects one packet per sort epoch into the PE's mesh sort slot.
- After the mesh sort completes, samples the packet delivered to this PE and commits it to the PE's local memory word when the address matches PE_ID.
- Sits between the PE's request logic and the mesh compare-exchange network. All 16 PEs run in lock-step from a shared epoch_start pulse.

---
 rtl/mesh_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/pe_write_port.sv | 118 +++++++++++
 3 files changed

// File: rtl/mesh_pkg.sv
// Shared constants, packet layout and epoch FSM encoding for the mesh write path.
// Every PE and the compare-exchange mesh agree on these definitions.
package mesh_pkg;
   localparam int DATA_WIDTH  = 32;
   localparam int ADDR_WIDTH  = 4;
   localparam int PKT_WIDTH   = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int SORT_CYCLES = 21;
   localparam int N           = 2 ** ADDR_WIDTH;

   // Packet layout, MSB first: {vld, addr, data}
   localparam int DATA_LSB = 0;
   localparam int ADDR_LSB = DATA_WIDTH;
   localparam int VLD_BIT  = DATA_WIDTH + ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      INJECT  = 2'd1,
      SORT    = 2'd2,
      DELIVER = 2'd3
   } state_t;

   // All-ones address makes empty slots sort after every valid packet.
   localparam logic [PKT_WIDTH-1:0] INVALID_PKT =
      {1'b0, {ADDR_WIDTH{1'b1}}, {DATA_WIDTH{1'b0}}};
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head so the entry can be injected
// in the same cycle it is popped.
module sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (PW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the slot this cycle, so a full FIFO may still take a push.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_reg[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= push_data;
   end
endmodule

// File: rtl/pe_write_port.sv
// Per-PE mesh write front end: queues local writes, injects one packet per
// sort epoch and commits the sorted packet that lands in this PE's slot.
module pe_write_port
   import mesh_pkg::*;
#(
   parameter int DATA_WIDTH  = mesh_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH  = mesh_pkg::ADDR_WIDTH,
   parameter int PKT_WIDTH   = 1 + ADDR_WIDTH + DATA_WIDTH,
   parameter int SORT_CYCLES = mesh_pkg::SORT_CYCLES,
   parameter int PE_ID       = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic                  epoch_start,
   output logic [PKT_WIDTH-1:0]  pkt_out,
   output logic                  pkt_load,
   input  logic [PKT_WIDTH-1:0]  pkt_in,
   output logic [DATA_WIDTH-1:0] memory,
   output logic                  busy,
   output logic                  epoch_done,
   output logic [7:0]            miss_count
);
   localparam int CW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(PE_ID);
   localparam logic [PKT_WIDTH-1:0]  EMPTY_PKT =
      {1'b0, {ADDR_WIDTH{1'b1}}, {DATA_WIDTH{1'b0}}};

   state_t                          state_reg, state_next;
   logic [CW-1:0]                   cnt_reg, cnt_next;
   logic [PKT_WIDTH-1:0]            pkt_hold_reg;
   logic [PKT_WIDTH-1:0]            inject_pkt;
   logic [DATA_WIDTH-1:0]           memory_reg;
   logic [7:0]                      miss_reg;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;
   logic                            fifo_empty;
   logic [FW:0]                     fifo_count;
   logic                            fifo_pop;
   logic                            in_vld;
   logic [ADDR_WIDTH-1:0]           in_addr;
   logic [DATA_WIDTH-1:0]           in_data;

   assign req_ready = (fifo_count != (FW+1)'(FIFO_DEPTH));

   sync_fifo #(
      .WIDTH (ADDR_WIDTH + DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid && req_ready),
      .push_data ({req_addr, req_data}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign in_vld  = pkt_in[PKT_WIDTH-1];
   assign in_addr = pkt_in[DATA_WIDTH +: ADDR_WIDTH];
   assign in_data = pkt_in[DATA_WIDTH-1:0];

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pkt_load   = 1'b0;
      epoch_done = 1'b0;
      fifo_pop   = 1'b0;
      inject_pkt = fifo_empty ? EMPTY_PKT : {1'b1, fifo_head};
      case (state_reg)
         IDLE:    if (epoch_start) state_next = INJECT;
         INJECT: begin
            pkt_load   = 1'b1;
            fifo_pop   = !fifo_empty;
            cnt_next   = CW'(SORT_CYCLES - 1);
            state_next = SORT;
         end
         SORT: begin
            if (cnt_reg == '0) state_next = DELIVER;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         DELIVER: begin
            epoch_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         pkt_hold_reg <= '0;
         memory_reg   <= '0;
         miss_reg     <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == INJECT) pkt_hold_reg <= inject_pkt;
         if (state_reg == DELIVER && in_vld) begin
            if (in_addr == MY_ADDR)    memory_reg <= in_data;
            else if (miss_reg != 8'hFF) miss_reg  <= miss_reg + 8'd1;
         end
      end
   end

   // The mesh only looks at pkt_out while pkt_load is high; otherwise it holds.
   assign pkt_out    = (state_reg == INJECT) ? inject_pkt : pkt_hold_reg;
   assign memory     = memory_reg;
   assign busy       = (state_reg != IDLE);
   assign miss_count = miss_reg;
endmodule
